// File: rtl/burst_seq_pkg.sv
// burst_seq_pkg: shared definitions for the burst sequencer slice.
//   - default address / length field widths
//   - FSM state encoding (plain constants for drop-in compatibility with
//     existing code that compares raw state values)
//   - burst type encoding as carried on the burst_type input
package burst_seq_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned LEN_W_DEF  = 4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_LEN  = 3'd1;
  localparam logic [2:0] S_LOAD_ADDR = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic BURST_INCR = 1'b0;
  localparam logic BURST_WRAP = 1'b1;

endpackage

// File: rtl/burst_cfg_sipo.sv
// burst_cfg_sipo: serial-in parallel-out shifter for configuration words,
// MSB first, with a received-bit count and a full flag.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear of contents and count (wins over shift_i)
//   shift_i     accept sdi_i this cycle (ignored once full)
//   sdi_i       serial data bit
//   nxt_o       complete word as it stands including the bit on sdi_i;
//               valid in the cycle fill_o is high
//   fill_o      the bit accepted this cycle completes the word
//   full_o      W bits have been received
// W must be at least 2.
module burst_cfg_sipo
  import burst_seq_pkg::*;
#(
  parameter int unsigned W = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         sdi_i,
  output logic [W-1:0] nxt_o,
  output logic         fill_o,
  output logic         full_o
);

  localparam int unsigned CW = $clog2(W + 1);

  // Only W-1 bits are stored: the final bit is taken straight from sdi_i so
  // the owner can capture the whole word in the same cycle it completes.
  logic [W-2:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          take;

  assign nxt_o  = {data_q, sdi_i};
  assign full_o = (cnt_q == CW'(W));
  assign take   = shift_i && !full_o;
  assign fill_o = take && (cnt_q == CW'(W - 1));

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (take) begin
      data_d = nxt_o[W-2:0];
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/burst_seq_ctrl.sv
// burst_seq_ctrl: address sequencer. A burst is configured serially
// (length then start address, MSB first) and its beats are issued over a
// valid/ready handshake; a single transfer can be requested directly.
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   block enable; low returns to IDLE, discarding work
//   mode_sel             0 single transfer, 1 burst (sampled in IDLE)
//   burst_type           0 INCR, 1 WRAP (sampled with last config bit)
//   cfg_sdi/cfg_sdi_vld  serial config bit and strobe
//   single_addr/_vld     single-transfer address and request
//   addr_out/addr_vld    issued address and valid
//   addr_rdy             downstream ready
//   last                 current beat is the final one
//   busy                 not IDLE
//   done                 one-cycle completion pulse
//   addr_sel             1 = generated burst address, 0 = single address
// Build option: define BURST_SEQ_WRAP_EN to enable WRAP bursts; without it
// burst_type is ignored and every burst increments linearly.
module burst_seq_ctrl
  import burst_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode_sel,
  input  logic              burst_type,
  input  logic              cfg_sdi,
  input  logic              cfg_sdi_vld,
  input  logic [ADDR_W-1:0] single_addr,
  input  logic              single_vld,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_vld,
  input  logic              addr_rdy,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              addr_sel
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_par, addr_inc, addr_step;
  logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d, len_par;
  logic              sel_q, sel_d;
  logic              len_shift, addr_shift, len_fill, addr_fill, sipo_clr;
  logic              last_beat;
  logic              unused_len_full, unused_addr_full;

  assign len_shift  = en && cfg_sdi_vld &&
                      ((state_q == S_IDLE && mode_sel) || state_q == S_LOAD_LEN);
  assign addr_shift = en && cfg_sdi_vld && (state_q == S_LOAD_ADDR);
  // Shifters are emptied whenever the FSM lands in IDLE, so an aborted
  // configuration never leaks into the next one.
  assign sipo_clr   = (state_d == S_IDLE);

  burst_cfg_sipo #(.W(LEN_W)) u_len_sipo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (sipo_clr),
    .shift_i (len_shift),
    .sdi_i   (cfg_sdi),
    .nxt_o   (len_par),
    .fill_o  (len_fill),
    .full_o  (unused_len_full)
  );

  burst_cfg_sipo #(.W(ADDR_W)) u_addr_sipo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (sipo_clr),
    .shift_i (addr_shift),
    .sdi_i   (cfg_sdi),
    .nxt_o   (addr_par),
    .fill_o  (addr_fill),
    .full_o  (unused_addr_full)
  );

  assign last_beat = (beat_q == len_q);
  assign addr_inc  = addr_q + 1'b1;

`ifdef BURST_SEQ_WRAP_EN
  logic              wrap_q, wrap_d;
  logic [LEN_W-1:0]  len_p1;
  logic [ADDR_W-1:0] wrap_mask;
  logic              len_pow2;

  // len+1 is a power of two exactly when len has no bit in common with
  // len+1 (all-ones len overflows to zero, which also qualifies).
  assign len_p1    = len_q + 1'b1;
  assign len_pow2  = ((len_q & len_p1) == '0);
  assign wrap_mask = ADDR_W'(len_q);
  assign addr_step = (wrap_q && len_pow2)
                   ? ((addr_q & ~wrap_mask) | (addr_inc & wrap_mask))
                   : addr_inc;
`else
  logic unused_burst_type;
  assign unused_burst_type = burst_type;
  assign addr_step         = addr_inc;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    sel_d   = sel_q;
`ifdef BURST_SEQ_WRAP_EN
    wrap_d  = wrap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mode_sel && cfg_sdi_vld) begin
          state_d = len_fill ? S_LOAD_ADDR : S_LOAD_LEN;
        end else if (!mode_sel && single_vld) begin
          state_d = S_ISSUE;
          addr_d  = single_addr;
          len_d   = '0;
          beat_d  = '0;
          sel_d   = 1'b0;
        end
      end
      S_LOAD_LEN: begin
        if (len_fill) state_d = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        if (addr_fill) begin
          state_d = S_ISSUE;
          addr_d  = addr_par;
          beat_d  = '0;
          sel_d   = 1'b1;
`ifdef BURST_SEQ_WRAP_EN
          wrap_d  = (burst_type == BURST_WRAP);
`endif
        end
      end
      S_ISSUE: begin
        if (addr_rdy) begin
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
            addr_d = addr_step;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (len_fill) len_d = len_par;
    if (!en)      state_d = S_IDLE;

    if (state_d == S_IDLE) begin
      addr_d = '0;
      len_d  = '0;
      beat_d = '0;
      sel_d  = 1'b0;
`ifdef BURST_SEQ_WRAP_EN
      wrap_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      sel_q   <= 1'b0;
`ifdef BURST_SEQ_WRAP_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      sel_q   <= sel_d;
`ifdef BURST_SEQ_WRAP_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  assign addr_out = addr_q;
  assign addr_vld = (state_q == S_ISSUE);
  assign last     = (state_q == S_ISSUE) && last_beat;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign addr_sel = sel_q;

endmodule

// File: tb/tb_burst_seq_ctrl.sv
// tb_burst_seq_ctrl: directed and randomised checks of burst_seq_ctrl
// against an address-sequence model derived from the burst rules.
module tb_burst_seq_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          mode_sel = 1'b0;
  logic          burst_type = 1'b0;
  logic          cfg_sdi = 1'b0;
  logic          cfg_sdi_vld = 1'b0;
  logic [AW-1:0] single_addr = '0;
  logic          single_vld = 1'b0;
  logic          addr_rdy = 1'b0;
  logic [AW-1:0] addr_out;
  logic          addr_vld, last, busy, done, addr_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  burst_seq_ctrl #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode_sel    (mode_sel),
    .burst_type  (burst_type),
    .cfg_sdi     (cfg_sdi),
    .cfg_sdi_vld (cfg_sdi_vld),
    .single_addr (single_addr),
    .single_vld  (single_vld),
    .addr_out    (addr_out),
    .addr_vld    (addr_vld),
    .addr_rdy    (addr_rdy),
    .last        (last),
    .busy        (busy),
    .done        (done),
    .addr_sel    (addr_sel)
  );

  // Address of beat i: WRAP stays inside the aligned block of len+1 beats
  // when that size is a power of two; otherwise linear modulo 2^AW.
  function automatic logic [AW-1:0] model_addr(input int unsigned len,
                                               input int unsigned a,
                                               input logic bt,
                                               input int unsigned i);
    int unsigned n;
    bit          wrap;
    n    = len + 1;
    wrap = bt && ((n & (n - 1)) == 0);
`ifndef BURST_SEQ_WRAP_EN
    wrap = 1'b0;
`endif
    if (wrap) return AW'((a - (a % n)) + (((a % n) + i) % n));
    return AW'((a + i) % 65536);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".addr_out"}, addr_out, 0);
    chk({tag, ".addr_vld"}, addr_vld, 0);
    chk({tag, ".last"}, last, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".addr_sel"}, addr_sel, 0);
  endtask

  // Shift nbits of {len, addr} MSB first; called at a negedge in IDLE.
  task automatic load_cfg(input logic [LW-1:0] len, input logic [AW-1:0] a,
                          input logic bt, input int nbits, input bit rnd);
    logic [LW+AW-1:0] bits;
    int               g;
    bits       = {len, a};
    mode_sel   = 1'b1;
    single_vld = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      if (rnd && k != 0) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          cfg_sdi_vld = 1'b0;
          cfg_sdi     = 1'($urandom);
          mode_sel    = 1'($urandom);
          single_vld  = 1'($urandom);
          burst_type  = 1'($urandom);
          @(negedge clk);
        end
      end
      cfg_sdi_vld = 1'b1;
      cfg_sdi     = bits[LW+AW-1-k];
      burst_type  = (k == LW + AW - 1 || !rnd) ? bt : 1'($urandom);
      @(negedge clk);
      if (k == 0) chk("load.busy", busy, 1);
    end
    cfg_sdi_vld = 1'b0;
    single_vld  = 1'b0;
  endtask

  // Called at the first negedge in ISSUE; returns at the first IDLE negedge.
  task automatic issue_phase(input logic [LW-1:0] len, input logic [AW-1:0] a,
                             input logic bt, input logic sel,
                             input int stall_beat, input bit rnd);
    int i;
    int stalls;
    int guard;
    i = 0; stalls = 0; guard = 0;
    while (i <= int'(len) && guard < 300) begin
      guard++;
      chk("issue.addr_out", addr_out, model_addr(len, a, bt, i));
      chk("issue.addr_vld", addr_vld, 1);
      chk("issue.last", last, (i == int'(len)));
      chk("issue.addr_sel", addr_sel, sel);
      chk("issue.done", done, 0);
      if (i == stall_beat && stalls < 3) begin
        addr_rdy = 1'b0;
        stalls++;
      end else begin
        addr_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (rnd) begin
        cfg_sdi_vld = 1'($urandom);
        cfg_sdi     = 1'($urandom);
        mode_sel    = 1'($urandom);
        single_vld  = 1'($urandom);
        burst_type  = 1'($urandom);
        single_addr = AW'($urandom);
      end
      @(negedge clk);
      if (addr_rdy) i++;
    end
    chk("issue.guard", (guard < 300), 1);
    addr_rdy    = 1'b0;
    cfg_sdi_vld = 1'b0;
    single_vld  = 1'b0;
    mode_sel    = 1'b0;
    chk("done.done", done, 1);
    chk("done.addr_vld", addr_vld, 0);
    chk("done.busy", busy, 1);
    chk("done.last", last, 0);
    @(negedge clk);
    chk_idle("after_done");
  endtask

  task automatic single(input logic [AW-1:0] a, input int stall_beat, input bit rnd);
    mode_sel    = 1'b0;
    single_addr = a;
    single_vld  = 1'b1;
    @(negedge clk);
    single_vld  = 1'b0;
    single_addr = AW'($urandom);
    issue_phase('0, a, 1'b0, 1'b0, stall_beat, rnd);
  endtask

  initial begin
    logic [LW-1:0] rl;
    logic [AW-1:0] ra;
    logic          rb;

    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    load_cfg(4'd3, 16'h0010, 1'b0, LW + AW, 1'b0);
    issue_phase(4'd3, 16'h0010, 1'b0, 1'b1, -1, 1'b0);

    load_cfg(4'd3, 16'h0016, 1'b1, LW + AW, 1'b0);
    issue_phase(4'd3, 16'h0016, 1'b1, 1'b1, -1, 1'b0);

    load_cfg(4'd2, 16'h0016, 1'b1, LW + AW, 1'b0);
    issue_phase(4'd2, 16'h0016, 1'b1, 1'b1, -1, 1'b0);

    load_cfg(4'd3, 16'hFFFE, 1'b0, LW + AW, 1'b0);
    issue_phase(4'd3, 16'hFFFE, 1'b0, 1'b1, -1, 1'b0);

    load_cfg(4'd7, 16'h0100, 1'b0, LW + AW, 1'b0);
    issue_phase(4'd7, 16'h0100, 1'b0, 1'b1, 2, 1'b0);

    single(16'h1234, -1, 1'b0);

    // Asynchronous reset while beat 2 is presented.
    load_cfg(4'd3, 16'h0040, 1'b0, LW + AW, 1'b0);
    addr_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    addr_rdy = 1'b0;
    chk("rst_mid.addr_out", addr_out, 16'h0042);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("rst_release");

    // Enable dropped part-way through the address field.
    load_cfg(4'd5, 16'hABCD, 1'b0, LW + 7, 1'b0);
    chk("en_low.busy_before", busy, 1);
    en = 1'b0;
    @(negedge clk);
    chk_idle("en_low");
    en = 1'b1;
    @(negedge clk);
    chk_idle("en_restore");
    load_cfg(4'd2, 16'h0300, 1'b0, LW + AW, 1'b0);
    issue_phase(4'd2, 16'h0300, 1'b0, 1'b1, -1, 1'b0);

    repeat (30) begin
      rl = LW'($urandom);
      ra = AW'($urandom);
      rb = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        single(ra, -1, 1'b1);
      end else begin
        load_cfg(rl, ra, rb, LW + AW, 1'b1);
        issue_phase(rl, ra, rb, 1'b1, -1, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
